// File: rtl/bcd_adder.sv
// Registered multi-digit BCD adder with ripple decimal carry and one-cycle latency.
// Optional BCD_INVALID_FLAG_EN adds a registered err flag for non-BCD operand digits.
module bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                Cin,
  output logic [4*DIGITS-1:0] s,
  output logic                Cout,
  output logic                out_valid
`ifdef BCD_INVALID_FLAG_EN
  ,
  output logic                err
`endif
);

  logic [4*DIGITS-1:0] sum_next;
  logic                carry;
  logic [4:0]          raw;

  // Digit sums above 9 (including non-BCD inputs) wrap by adding 6 and carry into the next digit.
  always_comb begin
    sum_next = '0;
    raw      = '0;
    carry    = Cin;
    for (int i = 0; i < DIGITS; i++) begin
      raw = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
      if (raw > 5'd9) begin
        sum_next[4*i +: 4] = 4'(raw + 5'd6);
        carry              = 1'b1;
      end else begin
        sum_next[4*i +: 4] = raw[3:0];
        carry              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_next;
        Cout <= carry;
      end
    end
  end

`ifdef BCD_INVALID_FLAG_EN
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_valid) begin
      err <= bad_digit;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Scoreboard testbench for bcd_adder: one DIGITS=1 instance and one DIGITS=2 instance
// share clock and reset; expected sums are queued at drive time and popped on out_valid.
module tb_bcd_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       err;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, c1, v2, c2;
  logic [3:0] a1, b1;
  logic [7:0] a2, b2;
  logic [3:0] s1;
  logic [7:0] s2;
  logic       co1, co2, ov1, ov2;
`ifdef BCD_INVALID_FLAG_EN
  logic       err1, err2;
`endif

  entry_t q1[$];
  entry_t q2[$];
  entry_t hold1, hold2;
  logic   monOn;
  int     checkCount = 0;
  int     passCount  = 0;

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .Cin(c1),
    .s(s1), .Cout(co1), .out_valid(ov1)
`ifdef BCD_INVALID_FLAG_EN
    , .err(err1)
`endif
  );

  bcd_adder #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .a(a2), .b(b2), .Cin(c2),
    .s(s2), .Cout(co2), .out_valid(ov2)
`ifdef BCD_INVALID_FLAG_EN
    , .err(err2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    else
      passCount++;
  endtask

  // Reference: per digit add, digit sums above 9 get +6 and produce a decimal carry.
  function automatic entry_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input int digits);
    entry_t r;
    int c, ai, bi, raw;
    r = '0;
    c = int'(cin);
    for (int i = 0; i < digits; i++) begin
      ai = int'(a[4*i +: 4]);
      bi = int'(b[4*i +: 4]);
      raw = ai + bi + c;
      if (raw > 9) begin
        r.s[4*i +: 4] = 4'((raw + 6) % 16);
        c = 1;
      end else begin
        r.s[4*i +: 4] = 4'(raw);
        c = 0;
      end
      if (ai > 9 || bi > 9) r.err = 1'b1;
    end
    r.co = c[0];
    return r;
  endfunction

  // sel selects the instance that captures this cycle; the other one idles.
  task automatic applyStimulus(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    if (sel == 1) begin
      v1 = 1'b1; a1 = a[3:0]; b1 = b[3:0]; c1 = cin;
      q1.push_back(model({4'h0, a[3:0]}, {4'h0, b[3:0]}, cin, 1));
    end else if (sel == 2) begin
      v2 = 1'b1; a2 = a; b2 = b; c2 = cin;
      q2.push_back(model(a, b, cin, 2));
    end else begin
      a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom);
      a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
    end
  endtask

  always @(posedge clk) begin : mon1
    logic sv;
    entry_t e;
    sv = v1;
    #1;
    if (monOn) begin
      checkOutput("ov1", 32'(ov1), 32'(sv));
      if (sv) begin
        if (q1.size() == 0) begin
          checkOutput("q1_underflow", 32'(q1.size()), 32'd1);
        end else begin
          e = q1.pop_front();
          checkOutput("s1", 32'(s1), 32'(e.s[3:0]));
          checkOutput("co1", 32'(co1), 32'(e.co));
`ifdef BCD_INVALID_FLAG_EN
          checkOutput("err1", 32'(err1), 32'(e.err));
`endif
          hold1 = e;
        end
      end else begin
        checkOutput("hold_s1", 32'(s1), 32'(hold1.s[3:0]));
        checkOutput("hold_co1", 32'(co1), 32'(hold1.co));
      end
    end
  end

  always @(posedge clk) begin : mon2
    logic sv;
    entry_t e;
    sv = v2;
    #1;
    if (monOn) begin
      checkOutput("ov2", 32'(ov2), 32'(sv));
      if (sv) begin
        if (q2.size() == 0) begin
          checkOutput("q2_underflow", 32'(q2.size()), 32'd1);
        end else begin
          e = q2.pop_front();
          checkOutput("s2", 32'(s2), 32'(e.s));
          checkOutput("co2", 32'(co2), 32'(e.co));
`ifdef BCD_INVALID_FLAG_EN
          checkOutput("err2", 32'(err2), 32'(e.err));
`endif
          hold2 = e;
        end
      end else begin
        checkOutput("hold_s2", 32'(s2), 32'(hold2.s));
        checkOutput("hold_co2", 32'(co2), 32'(hold2.co));
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s1"}, 32'(s1), 32'd0);
    checkOutput({tag, "_co1"}, 32'(co1), 32'd0);
    checkOutput({tag, "_ov1"}, 32'(ov1), 32'd0);
    checkOutput({tag, "_s2"}, 32'(s2), 32'd0);
    checkOutput({tag, "_co2"}, 32'(co2), 32'd0);
    checkOutput({tag, "_ov2"}, 32'(ov2), 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
    q1.delete(); q2.delete();
    hold1 = '0; hold2 = '0;
    rst = 1'b0;
    monOn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    monOn = 1'b0;
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
    hold1 = '0; hold2 = '0;
    #1;
    checkResetState("rst0");
    repeat (2) @(negedge clk);
    checkResetState("rst_held");
    releaseReset();

    // Directed single-digit cases, including carries and non-BCD extremes.
    applyStimulus(1, 8'd3, 8'd4, 1'b0);
    applyStimulus(1, 8'd9, 8'd9, 1'b1);
    applyStimulus(1, 8'd5, 8'd5, 1'b0);
    applyStimulus(1, 8'd15, 8'd15, 1'b1);
    applyStimulus(1, 8'd10, 8'd0, 1'b0);
    applyStimulus(1, 8'd12, 8'd1, 1'b0);
    repeat (3) applyStimulus(0, 8'd0, 8'd0, 1'b0);

    // Multi-digit cases.
    applyStimulus(2, 8'h99, 8'h01, 1'b0);
    applyStimulus(2, 8'h45, 8'h38, 1'b0);
    applyStimulus(2, 8'h99, 8'h99, 1'b1);
    applyStimulus(2, 8'h00, 8'h00, 1'b0);
    applyStimulus(2, 8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 40; k++) applyStimulus(2, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3) applyStimulus(0, 8'd0, 8'd0, 1'b0);

    // Exhaustive single-digit sweep, back to back.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          applyStimulus(1, 8'(x), 8'(y), c[0]);
    repeat (2) applyStimulus(0, 8'd0, 8'd0, 1'b0);

    // Asynchronous reset with non-zero results held, well away from any clock edge.
    applyStimulus(1, 8'd3, 8'd4, 1'b0);
    applyStimulus(2, 8'h45, 8'h38, 1'b0);
    @(posedge clk);
    #3;
    monOn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetState("async_rst");
    @(negedge clk);
    v1 = 1'b1; a1 = 4'd7; b1 = 4'd8; c1 = 1'b1;
    v2 = 1'b1; a2 = 8'h12; b2 = 8'h34; c2 = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("rst_hold_valid");
    releaseReset();
    repeat (2) applyStimulus(0, 8'd0, 8'd0, 1'b0);
    applyStimulus(1, 8'd8, 8'd7, 1'b0);
    applyStimulus(2, 8'h50, 8'h50, 1'b1);
    repeat (3) applyStimulus(0, 8'd0, 8'd0, 1'b0);

    @(negedge clk);
    checkOutput("q1_empty", 32'(q1.size()), 32'd0);
    checkOutput("q2_empty", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
